// File: rtl/spi_rsp.sv
// spi_rsp: SPI mode-0 responder (slave end), MSB first, oversampled in the clk domain.
//
// The SCLK, SS_N and MOSI inputs are each synchronized, then passed through an edge-detect
// register. The rx path shifts MOSI on detected SCLK rises. MISO is driven from a shift
// register that is loaded from a 1-deep tx holding register when SS_N falls.
//
// Ports:
//   clk, sresetn             system clock and async active-low reset
//   SCLK, SS_N, MOSI, MISO   SPI pins; MISO is 0 outside SHIFT
//   tx_data/valid/ready      host -> holding register (valid/ready handshake)
//   rx_data, rx_len          last frame: right-justified bits and the bit count (saturating)
//   rx_valid                 1-clk pulse when rx_data, rx_len and the flags update
//   rx_overrun, tx_underrun  flags for the last frame
//   busy                     frame in progress
module spi_rsp #(
    parameter int SPI_MAXLEN  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          sresetn,
    input  logic                          SCLK,
    input  logic                          SS_N,
    input  logic                          MOSI,
    output logic                          MISO,
    input  logic [SPI_MAXLEN-1:0]         tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [SPI_MAXLEN-1:0]         rx_data,
    output logic [$clog2(SPI_MAXLEN):0]   rx_len,
    output logic                          rx_valid,
    output logic                          rx_overrun,
    output logic                          tx_underrun,
    output logic                          busy
);
    localparam int W  = SPI_MAXLEN;
    localparam int CW = $clog2(SPI_MAXLEN) + 1;
    localparam logic [CW-1:0] MAXCNT = CW'(SPI_MAXLEN);

    typedef enum logic [1:0] {RESYNC, IDLE, SHIFT, DONE} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic                   sclk_prev, ss_prev, mosi_q;
    logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;
    // vld_pipe fills with ones after reset. Its top bit marks the point where the
    // synchronizers and edge registers reflect the pins rather than their reset values.
    logic [SYNC_STAGES:0]   vld_pipe;
    logic                   primed;

    logic [W-1:0]  hold_data, shift_reg, rx_shift;
    logic          hold_full, underrun_n, overrun_n;
    logic [CW-1:0] cnt;

    assign primed   = vld_pipe[SYNC_STAGES];
    assign tx_ready = ~hold_full;
    assign busy     = (state == SHIFT) || (state == DONE);

    // Synchronizers and edge detection
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b1;
            mosi_q    <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            ss_rise   <= 1'b0;
            ss_fall   <= 1'b0;
            vld_pipe  <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_N};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            ss_prev   <= ss_sync[SYNC_STAGES-1];
            // MOSI is registered alongside the edge pulses so the rise samples it aligned
            mosi_q    <= mosi_sync[SYNC_STAGES-1];
            sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
            sclk_fall <= ~sclk_sync[SYNC_STAGES-1] & sclk_prev;
            ss_rise   <= ss_sync[SYNC_STAGES-1] & ~ss_prev;
            ss_fall   <= ~ss_sync[SYNC_STAGES-1] & ss_prev;
            vld_pipe  <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) state <= RESYNC;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RESYNC: if (primed && ss_prev) state_nxt = IDLE;
            IDLE:   if (ss_fall)           state_nxt = SHIFT;
            SHIFT:  if (ss_rise)           state_nxt = DONE;
            DONE:                          state_nxt = IDLE;
            default:                       state_nxt = RESYNC;
        endcase
    end

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            MISO        <= 1'b0;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            shift_reg   <= '0;
            rx_shift    <= '0;
            cnt         <= '0;
            underrun_n  <= 1'b0;
            overrun_n   <= 1'b0;
            rx_data     <= '0;
            rx_len      <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            // A load in the SS_N-fall clock wins over the frame's take. The frame itself
            // still sees the holding register as it was before the load.
            if (tx_valid && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= tx_data;
            end else if (state == IDLE && ss_fall) begin
                hold_full <= 1'b0;
            end

            case (state)
                IDLE: begin
                    MISO <= 1'b0;
                    if (ss_fall) begin
                        shift_reg  <= hold_full ? hold_data : '0;
                        MISO       <= hold_full & hold_data[W-1];
                        underrun_n <= ~hold_full;
                        overrun_n  <= 1'b0;
                        cnt        <= '0;
                        rx_shift   <= '0;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        rx_shift <= {rx_shift[W-2:0], mosi_q};
                        if (cnt == MAXCNT) overrun_n <= 1'b1;
                        else               cnt       <= cnt + 1'b1;
                    end
                    if (sclk_fall) begin
                        shift_reg <= shift_reg << 1;
                        MISO      <= shift_reg[W-2];
                    end
                end
                DONE: begin
                    rx_valid    <= 1'b1;
                    rx_data     <= rx_shift;
                    rx_len      <= cnt;
                    rx_overrun  <= overrun_n;
                    tx_underrun <= underrun_n;
                    MISO        <= 1'b0;
                end
                default: MISO <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_rsp.sv
// tb_spi_rsp: directed bench for spi_rsp. It acts as a mode-0 master at clk/10, collects
// MISO just before each SCLK rise, and counts rx_valid pulses on the falling clk edge.
module tb_spi_rsp;
    logic        clk = 1'b0;
    logic        sresetn = 1'b0;
    logic        SCLK = 1'b0, SS_N = 1'b1, MOSI = 1'b0;
    logic        MISO;
    logic [15:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic [4:0]  rx_len;
    logic        rx_valid, rx_overrun, tx_underrun, busy;

    int total = 0;
    int bad   = 0;
    int rv_cnt = 0;
    int rv_base;
    logic [31:0] mi;
    logic        miso_seen;

    spi_rsp #(.SPI_MAXLEN(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .sresetn(sresetn), .SCLK(SCLK), .SS_N(SS_N), .MOSI(MOSI), .MISO(MISO),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_len(rx_len), .rx_valid(rx_valid),
        .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rx_valid) rv_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [15:0] w);
        @(negedge clk);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic frame(input logic [31:0] mo, input int n, input logic mid_en,
                         input logic [15:0] mid_w, output logic [31:0] miso_w);
        miso_w = '0;
        @(negedge clk);
        SS_N = 1'b0;
        for (int i = 0; i < n; i++) begin
            MOSI = mo[n-1-i];
            if (mid_en && i == 4) begin
                tx_data  = mid_w;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                repeat (4) @(negedge clk);
            end else begin
                repeat (5) @(negedge clk);
            end
            miso_w = {miso_w[30:0], MISO};
            SCLK = 1'b1;
            repeat (5) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (5) @(negedge clk);
        SS_N = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_miso", 32'(MISO), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_rx_len", 32'(rx_len), 32'd0);
        chk("rst_flags", {30'd0, rx_overrun, tx_underrun}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        sresetn = 1'b1;
        repeat (10) @(negedge clk);

        // 16-bit frame
        load(16'hA5C3);
        chk("f1_tx_ready_after_load", 32'(tx_ready), 32'd0);
        rv_base = rv_cnt;
        frame(32'h1234, 16, 1'b0, 16'h0, mi);
        chk("f1_miso", mi, 32'hA5C3);
        chk("f1_rv_pulses", 32'(rv_cnt - rv_base), 32'd1);
        chk("f1_rx_data", 32'(rx_data), 32'h1234);
        chk("f1_rx_len", 32'(rx_len), 32'd16);
        chk("f1_flags", {30'd0, rx_overrun, tx_underrun}, 32'd0);
        chk("f1_tx_ready", 32'(tx_ready), 32'd1);
        chk("f1_busy", 32'(busy), 32'd0);

        // 8-bit frame
        load(16'hF000);
        rv_base = rv_cnt;
        frame(32'h5A, 8, 1'b0, 16'h0, mi);
        chk("f2_miso", mi, 32'hF0);
        chk("f2_rv_pulses", 32'(rv_cnt - rv_base), 32'd1);
        chk("f2_rx_data", 32'(rx_data), 32'h005A);
        chk("f2_rx_len", 32'(rx_len), 32'd8);

        // underrun: nothing loaded
        rv_base = rv_cnt;
        frame(32'hFFFF, 16, 1'b0, 16'h0, mi);
        chk("f3_miso", mi, 32'h0);
        chk("f3_underrun", 32'(tx_underrun), 32'd1);
        chk("f3_tx_ready", 32'(tx_ready), 32'd1);
        chk("f3_rx_data", 32'(rx_data), 32'hFFFF);

        // overrun: 20 rises
        load(16'hFFFF);
        rv_base = rv_cnt;
        frame(32'hFFFFF, 20, 1'b0, 16'h0, mi);
        chk("f4_miso", mi, 32'hFFFF0);
        chk("f4_rx_len", 32'(rx_len), 32'd16);
        chk("f4_overrun", 32'(rx_overrun), 32'd1);
        chk("f4_underrun", 32'(tx_underrun), 32'd0);
        chk("f4_rx_data", 32'(rx_data), 32'hFFFF);

        // zero-bit frame, also an underrun
        rv_base = rv_cnt;
        frame(32'h0, 0, 1'b0, 16'h0, mi);
        chk("f5_rv_pulses", 32'(rv_cnt - rv_base), 32'd1);
        chk("f5_rx_len", 32'(rx_len), 32'd0);
        chk("f5_underrun", 32'(tx_underrun), 32'd1);
        chk("f5_overrun", 32'(rx_overrun), 32'd0);

        // reset after 5 bits, released while SS_N is still low
        load(16'hFFFF);
        rv_base = rv_cnt;
        @(negedge clk);
        SS_N = 1'b0;
        for (int i = 0; i < 5; i++) begin
            MOSI = 1'b1;
            repeat (5) @(negedge clk);
            SCLK = 1'b1;
            repeat (5) @(negedge clk);
            SCLK = 1'b0;
        end
        #1;
        chk("r_busy_mid_frame", 32'(busy), 32'd1);
        chk("r_miso_mid_frame", 32'(MISO), 32'd1);
        @(negedge clk);
        sresetn = 1'b0;
        #1;
        chk("r_miso_in_reset", 32'(MISO), 32'd0);
        repeat (2) @(negedge clk);
        sresetn = 1'b1;
        miso_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            repeat (5) @(negedge clk);
            miso_seen = miso_seen | MISO | busy;
            SCLK = 1'b1;
            repeat (5) @(negedge clk);
            miso_seen = miso_seen | MISO | busy;
            SCLK = 1'b0;
        end
        repeat (5) @(negedge clk);
        SS_N = 1'b1;
        repeat (12) @(negedge clk);
        chk("r_miso_busy_quiet", 32'(miso_seen), 32'd0);
        chk("r_rv_pulses", 32'(rv_cnt - rv_base), 32'd0);
        chk("r_rx_len", 32'(rx_len), 32'd0);
        chk("r_tx_ready", 32'(tx_ready), 32'd1);
        load(16'h1357);
        rv_base = rv_cnt;
        frame(32'hBEEF, 16, 1'b0, 16'h0, mi);
        chk("r_next_miso", mi, 32'h1357);
        chk("r_next_rx_data", 32'(rx_data), 32'hBEEF);
        chk("r_next_rv_pulses", 32'(rv_cnt - rv_base), 32'd1);

        // back-to-back frames, second word loaded during the first frame
        load(16'h1111);
        rv_base = rv_cnt;
        frame(32'hAAAA, 16, 1'b1, 16'h2222, mi);
        chk("b1_miso", mi, 32'h1111);
        chk("b1_rx_data", 32'(rx_data), 32'hAAAA);
        chk("b1_tx_ready_held", 32'(tx_ready), 32'd0);
        frame(32'h5555, 16, 1'b0, 16'h0, mi);
        chk("b2_miso", mi, 32'h2222);
        chk("b2_rx_data", 32'(rx_data), 32'h5555);
        chk("b2_underrun", 32'(tx_underrun), 32'd0);
        chk("b_rv_pulses", 32'(rv_cnt - rv_base), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
